// File: rtl/comb_logic_unit.sv
// Registered wrapper around a 3-input "silly" function, a bitwise gate bank
// and an AND reduction; results load one clock after a qualifying in_valid.
module comb_logic_unit #(
    parameter int W  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          sa,
    input  logic          sb,
    input  logic          sc,
    input  logic [W-1:0]  ga,
    input  logic [W-1:0]  gb,
    input  logic [AW-1:0] ra,
    output logic          out_valid,
    output logic          sy,
    output logic [W-1:0]  yinv,
    output logic [W-1:0]  yand,
    output logic [W-1:0]  yor,
    output logic [W-1:0]  yxor,
    output logic [W-1:0]  ynand,
    output logic [W-1:0]  ynor,
    output logic          ry
);

    logic          sy_next;
    logic          ry_next;
    logic [W-1:0]  yinv_next;
    logic [W-1:0]  yand_next;
    logic [W-1:0]  yor_next;
    logic [W-1:0]  yxor_next;
    logic [W-1:0]  ynand_next;
    logic [W-1:0]  ynor_next;

    logic          out_valid_reg;
    logic          sy_reg;
    logic          ry_reg;
    logic [W-1:0]  yinv_reg;
    logic [W-1:0]  yand_reg;
    logic [W-1:0]  yor_reg;
    logic [W-1:0]  yxor_reg;
    logic [W-1:0]  ynand_reg;
    logic [W-1:0]  ynor_reg;

    // Minterms 000, 100 and 101 reduce to ~b & (a | ~c).
    assign sy_next = ~sb & (sa | ~sc);
    assign ry_next = &ra;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign yinv_next[gi]  = ~ga[gi];
            assign yand_next[gi]  = ga[gi] & gb[gi];
            assign yor_next[gi]   = ga[gi] | gb[gi];
            assign yxor_next[gi]  = ga[gi] ^ gb[gi];
            assign ynand_next[gi] = ~(ga[gi] & gb[gi]);
            assign ynor_next[gi]  = ~(ga[gi] | gb[gi]);
        end
    endgenerate

    // Results hold across invalid cycles; only out_valid follows in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            sy_reg        <= 1'b0;
            ry_reg        <= 1'b0;
            yinv_reg      <= '0;
            yand_reg      <= '0;
            yor_reg       <= '0;
            yxor_reg      <= '0;
            ynand_reg     <= '0;
            ynor_reg      <= '0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                sy_reg    <= sy_next;
                ry_reg    <= ry_next;
                yinv_reg  <= yinv_next;
                yand_reg  <= yand_next;
                yor_reg   <= yor_next;
                yxor_reg  <= yxor_next;
                ynand_reg <= ynand_next;
                ynor_reg  <= ynor_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sy        = sy_reg;
    assign ry        = ry_reg;
    assign yinv      = yinv_reg;
    assign yand      = yand_reg;
    assign yor       = yor_reg;
    assign yxor      = yxor_reg;
    assign ynand     = ynand_reg;
    assign ynor      = ynor_reg;

endmodule

// File: tb/tb_comb_logic_unit.sv
// Self-checking bench for comb_logic_unit: directed vector table, exhaustive
// sweeps, randomized traffic against a reference model, hold and reset cases.
module tb_comb_logic_unit;

    localparam int W  = 4;
    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          sa, sb, sc;
    logic [W-1:0]  ga, gb;
    logic [AW-1:0] ra;
    logic          out_valid, sy, ry;
    logic [W-1:0]  yinv, yand, yor, yxor, ynand, ynor;

    int checks = 0;
    int errors = 0;

    comb_logic_unit #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .sa(sa), .sb(sb), .sc(sc), .ga(ga), .gb(gb), .ra(ra),
        .out_valid(out_valid), .sy(sy),
        .yinv(yinv), .yand(yand), .yor(yor), .yxor(yxor),
        .ynand(ynand), .ynor(ynor), .ry(ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ov;
        logic         sy;
        logic [W-1:0] yinv, yand, yor, yxor, ynand, ynor;
        logic         ry;
    } exp_t;

    typedef struct {
        logic          sa, sb, sc;
        logic [W-1:0]  ga, gb;
        logic [AW-1:0] ra;
        exp_t          e;
    } vec_t;

    exp_t cur;
    exp_t zero_e;

    // Reference: silly function read from its truth table, gate bank and
    // reduction from plain word-level operators.
    function automatic exp_t model(logic a, logic b, logic c,
                                   logic [W-1:0] x, logic [W-1:0] y,
                                   logic [AW-1:0] r);
        exp_t m;
        logic [7:0] tt;
        tt      = 8'b0011_0001;
        m.ov    = 1'b1;
        m.sy    = tt[{a, b, c}];
        m.yinv  = W'(15 - x);
        m.yand  = x & y;
        m.yor   = x | y;
        m.yxor  = x ^ y;
        m.ynand = ~m.yand;
        m.ynor  = ~m.yor;
        m.ry    = (r == 8'd255);
        return m;
    endfunction

    task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic compare_all(string tag, exp_t e);
        chk(tag, "out_valid", 32'(out_valid), 32'(e.ov));
        chk(tag, "sy",        32'(sy),        32'(e.sy));
        chk(tag, "yinv",      32'(yinv),      32'(e.yinv));
        chk(tag, "yand",      32'(yand),      32'(e.yand));
        chk(tag, "yor",       32'(yor),       32'(e.yor));
        chk(tag, "yxor",      32'(yxor),      32'(e.yxor));
        chk(tag, "ynand",     32'(ynand),     32'(e.ynand));
        chk(tag, "ynor",      32'(ynor),      32'(e.ynor));
        chk(tag, "ry",        32'(ry),        32'(e.ry));
        $display("txn %-10s ov=%0b sy=%0b inv=%h and=%h or=%h xor=%h nand=%h nor=%h ry=%0b",
                 tag, out_valid, sy, yinv, yand, yor, yxor, ynand, ynor, ry);
    endtask

    // One clock edge; the model state advances from the inputs seen at the edge.
    task automatic step(string tag);
        @(posedge clk);
        if (in_valid) cur = model(sa, sb, sc, ga, gb, ra);
        else          cur.ov = 1'b0;
        #1;
        compare_all(tag, cur);
    endtask

    task automatic drive(logic v, logic a, logic b, logic c,
                         logic [W-1:0] x, logic [W-1:0] y, logic [AW-1:0] r);
        in_valid = v; sa = a; sb = b; sc = c; ga = x; gb = y; ra = r;
    endtask

    vec_t tbl[12];

    initial begin
        zero_e = '{ov: 1'b0, sy: 1'b0, yinv: '0, yand: '0, yor: '0, yxor: '0,
                   ynand: '0, ynor: '0, ry: 1'b0};
        // Silly truth table abc = 000..111 -> 1,0,0,0,1,1,0,0 with ga=gb=ra=0.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            logic [7:0] sy_tab;
            abc    = 3'(i);
            sy_tab = 8'b0011_0001;
            tbl[i] = '{sa: abc[2], sb: abc[1], sc: abc[0], ga: 4'h0, gb: 4'h0, ra: 8'h00,
                       e: '{ov: 1'b1, sy: sy_tab[i], yinv: 4'hF, yand: 4'h0, yor: 4'h0,
                            yxor: 4'h0, ynand: 4'hF, ynor: 4'hF, ry: 1'b0}};
        end
        tbl[8]  = '{sa: 1'b0, sb: 1'b0, sc: 1'b0, ga: 4'b1100, gb: 4'b1010, ra: 8'h00,
                    e: '{ov: 1'b1, sy: 1'b1, yinv: 4'b0011, yand: 4'b1000, yor: 4'b1110,
                         yxor: 4'b0110, ynand: 4'b0111, ynor: 4'b0001, ry: 1'b0}};
        tbl[9]  = '{sa: 1'b0, sb: 1'b0, sc: 1'b0, ga: 4'h0, gb: 4'h0, ra: 8'hFF,
                    e: '{ov: 1'b1, sy: 1'b1, yinv: 4'hF, yand: 4'h0, yor: 4'h0,
                         yxor: 4'h0, ynand: 4'hF, ynor: 4'hF, ry: 1'b1}};
        tbl[10] = '{sa: 1'b0, sb: 1'b0, sc: 1'b0, ga: 4'h0, gb: 4'h0, ra: 8'hFE,
                    e: '{ov: 1'b1, sy: 1'b1, yinv: 4'hF, yand: 4'h0, yor: 4'h0,
                         yxor: 4'h0, ynand: 4'hF, ynor: 4'hF, ry: 1'b0}};
        tbl[11] = '{sa: 1'b0, sb: 1'b0, sc: 1'b0, ga: 4'h0, gb: 4'h0, ra: 8'h7F,
                    e: '{ov: 1'b1, sy: 1'b1, yinv: 4'hF, yand: 4'h0, yor: 4'h0,
                         yxor: 4'h0, ynand: 4'hF, ynor: 4'hF, ry: 1'b0}};

        // Reset asserted from time zero: outputs must already read 0.
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'hA, 8'hFF);
        cur = zero_e;
        #3;
        compare_all("reset", zero_e);
        @(posedge clk); #1;
        compare_all("rst_edge", zero_e);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'hA, 8'hFF);
        step("idle0");
        step("idle1");

        // Directed table, applied back to back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].sa, tbl[i].sb, tbl[i].sc, tbl[i].ga, tbl[i].gb, tbl[i].ra);
            @(posedge clk); #1;
            compare_all($sformatf("vec%0d", i), tbl[i].e);
            cur = tbl[i].e;
        end

        // Exhaustive (ga, gb) and ra sweep.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), v[7:4], v[3:0], v);
            step($sformatf("sweep%0d", i));
        end

        // Hold: one valid result, then three invalid cycles with changed inputs.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 8'hFF);
        step("hold_ld");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 4'(i), 4'hF, 8'(i));
            step($sformatf("hold%0d", i));
            chk("hold", "ry", 32'(ry), 32'd1);
            chk("hold", "yor", 32'(yor), 32'hF);
            chk("hold", "yand", 32'(yand), 32'h0);
            chk("hold", "out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random valid gaps.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
            step($sformatf("rnd%0d", i));
        end

        // Reset mid-stream: partial-cycle pulse, then one held across an edge.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 8'hFF);
            step($sformatf("pre_rst%0d", i));
        end
        reset = 1'b1;
        #2;
        cur = zero_e;
        compare_all("rst_mid", zero_e);
        #2;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 4'h6, 8'hFF);
        step("post_rst");
        reset = 1'b1;
        #1;
        compare_all("rst_again", zero_e);
        cur = zero_e;
        @(posedge clk); #1;
        compare_all("rst_discard", zero_e);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 4'hC, 8'h0F);
        step("post_rst2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
        step("tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
